// File: rtl/dram_init_pkg.sv
// Shared constants, types and step helpers for the DRAM init sequencer.
// Define DRAM_INIT_ZQCL_EN to include the ZQ calibration block in the step list.
package dram_init_pkg;

   localparam logic [7:0] CSR_CONTROL  = 8'h00;
   localparam logic [7:0] CSR_COMMAND  = 8'h04;
   localparam logic [7:0] CSR_ISSUE    = 8'h08;
   localparam logic [7:0] CSR_ADDRESS  = 8'h0C;
   localparam logic [7:0] CSR_BADDRESS = 8'h10;

   localparam logic [31:0] CTRL_SEL     = 32'h01;
   localparam logic [31:0] CTRL_CKE     = 32'h02;
   localparam logic [31:0] CTRL_ODT     = 32'h04;
   localparam logic [31:0] CTRL_RESET_N = 32'h08;

   localparam logic [31:0] CMD_CS  = 32'h01;
   localparam logic [31:0] CMD_WE  = 32'h02;
   localparam logic [31:0] CMD_CAS = 32'h04;
   localparam logic [31:0] CMD_RAS = 32'h08;

   localparam logic [31:0] ISSUE_GO = 32'h01;

`ifdef DRAM_INIT_ZQCL_EN
   localparam int ZQ_STEPS = 5;
`else
   localparam int ZQ_STEPS = 0;
`endif

   // reset/cke block (6) + five MR blocks (25) + DLL lock delay (1) + ZQ + final CONTROL (1)
   localparam int NUM_STEPS = 33 + ZQ_STEPS;
   localparam int STEP_W    = 6;
   localparam logic [STEP_W-1:0] LAST_IDX = STEP_W'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, WRITE, DELAY, DONE, ERROR
   } state_e;

   typedef enum logic [2:0] {
      DLY_RESET, DLY_CKE, DLY_MRD, DLY_DLLK, DLY_ZQINIT
   } dly_sel_e;

   typedef struct packed {
      logic       is_delay;
      logic [7:0] offset;
      logic [31:0] data;
      dly_sel_e   dly_sel;
   } step_t;

   function automatic step_t wr_step(input logic [7:0] off, input logic [31:0] d);
      step_t s;
      s.is_delay = 1'b0;
      s.offset   = off;
      s.data     = d;
      s.dly_sel  = DLY_RESET;
      return s;
   endfunction

   function automatic step_t dly_step(input dly_sel_e sel);
      step_t s;
      s.is_delay = 1'b1;
      s.offset   = 8'h00;
      s.data     = 32'h0;
      s.dly_sel  = sel;
      return s;
   endfunction

endpackage

// File: rtl/dram_init_step_rom.sv
// Combinational step table: step index -> CSR write or delay record, plus last-step flag.
// The ZQ calibration steps are present only when DRAM_INIT_ZQCL_EN is defined.
module dram_init_step_rom
   import dram_init_pkg::*;
#(
   parameter logic [13:0] MR0_VAL = 14'h220,
   parameter logic [13:0] MR1_VAL = 14'h006,
   parameter logic [13:0] MR2_VAL = 14'h200,
   parameter logic [13:0] MR3_VAL = 14'h000
) (
   input  logic [STEP_W-1:0] idx,
   output step_t             step,
   output logic              last
);

   // MR programming order; the fourth entry sets the DLL-reset bit of MR0
   localparam logic [13:0] MR_VAL [5] = '{MR2_VAL, MR3_VAL, MR1_VAL, MR0_VAL | 14'h100, MR0_VAL};
   localparam logic [1:0]  MR_BA  [5] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0};

   step_t step_tbl [NUM_STEPS];

   assign step_tbl[0] = dly_step(DLY_RESET);
   assign step_tbl[1] = wr_step(CSR_ADDRESS, 32'h0);
   assign step_tbl[2] = wr_step(CSR_BADDRESS, 32'h0);
   assign step_tbl[3] = wr_step(CSR_CONTROL, CTRL_ODT | CTRL_RESET_N);
   assign step_tbl[4] = wr_step(CSR_CONTROL, CTRL_CKE | CTRL_ODT | CTRL_RESET_N);
   assign step_tbl[5] = dly_step(DLY_CKE);

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_mr
         localparam int B = 6 + 5 * gi;
         assign step_tbl[B]     = wr_step(CSR_ADDRESS, {18'd0, MR_VAL[gi]});
         assign step_tbl[B + 1] = wr_step(CSR_BADDRESS, {30'd0, MR_BA[gi]});
         assign step_tbl[B + 2] = wr_step(CSR_COMMAND, CMD_CS | CMD_WE | CMD_CAS | CMD_RAS);
         assign step_tbl[B + 3] = wr_step(CSR_ISSUE, ISSUE_GO);
         assign step_tbl[B + 4] = dly_step(DLY_MRD);
      end
   endgenerate

   assign step_tbl[31] = dly_step(DLY_DLLK);

`ifdef DRAM_INIT_ZQCL_EN
   assign step_tbl[32] = wr_step(CSR_ADDRESS, 32'h400);
   assign step_tbl[33] = wr_step(CSR_BADDRESS, 32'h0);
   assign step_tbl[34] = wr_step(CSR_COMMAND, CMD_CS | CMD_WE);
   assign step_tbl[35] = wr_step(CSR_ISSUE, ISSUE_GO);
   assign step_tbl[36] = dly_step(DLY_ZQINIT);
`endif

   assign step_tbl[NUM_STEPS - 1] = wr_step(CSR_CONTROL, CTRL_SEL);

   assign step = (idx <= LAST_IDX) ? step_tbl[idx] : '0;
   assign last = (idx == LAST_IDX);

endmodule

// File: rtl/dram_init_sequencer.sv
// DRAM power-up sequencer: walks a fixed step list issuing Wishbone CSR writes and delays.
// Define DRAM_INIT_ZQCL_EN to add the ZQ calibration writes and delay.
module dram_init_sequencer
   import dram_init_pkg::*;
#(
   parameter logic [31:0] CSR_BASE       = 32'h00009000,
   parameter logic [13:0] MR0_VAL        = 14'h220,
   parameter logic [13:0] MR1_VAL        = 14'h006,
   parameter logic [13:0] MR2_VAL        = 14'h200,
   parameter logic [13:0] MR3_VAL        = 14'h000,
   parameter logic [63:0] T_RESET_CYC    = 64'd20000,
   parameter logic [63:0] T_CKE_CYC      = 64'd50000,
   parameter logic [63:0] T_MRD_CYC      = 64'd4,
   parameter logic [63:0] T_DLLK_CYC     = 64'd512,
   parameter logic [63:0] T_ZQINIT_CYC   = 64'd512,
   parameter logic [63:0] WB_TIMEOUT_CYC = 64'd1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [29:0] wb_adr,
   output logic [31:0] wb_dat_w,
   output logic [3:0]  wb_sel,
   output logic        wb_we,
   output logic        wb_cyc,
   output logic        wb_stb,
   input  logic        wb_ack,
   input  logic        wb_err,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [63:0] MAX_CYC = 64'h0000_0000_FFFF_FFFF;

   generate
      if (T_RESET_CYC > MAX_CYC || T_CKE_CYC > MAX_CYC || T_MRD_CYC > MAX_CYC ||
          T_DLLK_CYC > MAX_CYC || T_ZQINIT_CYC > MAX_CYC || WB_TIMEOUT_CYC > MAX_CYC) begin : g_bad_param
         $error("dram_init_sequencer: cycle parameters must be below 2**32");
      end
   endgenerate

   // WRITE lasts WB_TIMEOUT_CYC cycles when no response arrives
   localparam logic [31:0] TMO_LOAD = (WB_TIMEOUT_CYC == 64'd0) ? 32'd0 : 32'(WB_TIMEOUT_CYC - 64'd1);

   state_e              state_reg, state_next;
   logic [STEP_W-1:0]   step_idx_reg, step_idx_next;
   logic [31:0]         dly_cnt_reg, dly_cnt_next;
   logic [31:0]         tmo_cnt_reg, tmo_cnt_next;
   logic                end_reg, end_next;

   step_t               step;
   logic                step_last;
   logic [31:0]         dly_val;
   logic [31:0]         csr_sum;
   logic                in_write;
   logic                unused_adr_lsb;

   dram_init_step_rom #(
      .MR0_VAL (MR0_VAL),
      .MR1_VAL (MR1_VAL),
      .MR2_VAL (MR2_VAL),
      .MR3_VAL (MR3_VAL)
   ) u_rom (
      .idx  (step_idx_reg),
      .step (step),
      .last (step_last)
   );

   always_comb begin
      dly_val = 32'd0;
      case (step.dly_sel)
         DLY_RESET:  dly_val = T_RESET_CYC[31:0];
         DLY_CKE:    dly_val = T_CKE_CYC[31:0];
         DLY_MRD:    dly_val = T_MRD_CYC[31:0];
         DLY_DLLK:   dly_val = T_DLLK_CYC[31:0];
         DLY_ZQINIT: dly_val = T_ZQINIT_CYC[31:0];
         default:    dly_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         step_idx_reg <= '0;
         dly_cnt_reg  <= '0;
         tmo_cnt_reg  <= '0;
         end_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         step_idx_reg <= step_idx_next;
         dly_cnt_reg  <= dly_cnt_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         end_reg      <= end_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      step_idx_next = step_idx_reg;
      dly_cnt_next  = dly_cnt_reg;
      tmo_cnt_next  = tmo_cnt_reg;
      end_next      = end_reg;
      case (state_reg)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_next    = FETCH;
               step_idx_next = '0;
               dly_cnt_next  = '0;
               tmo_cnt_next  = '0;
               end_next      = 1'b0;
            end
         end
         FETCH: begin
            if (end_reg) begin
               state_next = DONE;
            end else if (step.is_delay) begin
               // a zero-length delay is consumed here without visiting DELAY
               if (dly_val == 32'd0) begin
                  step_idx_next = step_idx_reg + STEP_W'(1);
                  end_next      = step_last;
               end else begin
                  state_next   = DELAY;
                  dly_cnt_next = dly_val;
               end
            end else begin
               state_next   = WRITE;
               tmo_cnt_next = TMO_LOAD;
            end
         end
         WRITE: begin
            if (wb_err) begin
               state_next = ERROR;
            end else if (wb_ack) begin
               state_next    = FETCH;
               step_idx_next = step_idx_reg + STEP_W'(1);
               end_next      = step_last;
            end else if (tmo_cnt_reg == 32'd0) begin
               state_next = ERROR;
            end else begin
               tmo_cnt_next = tmo_cnt_reg - 32'd1;
            end
         end
         DELAY: begin
            if (dly_cnt_reg <= 32'd1) begin
               state_next    = FETCH;
               dly_cnt_next  = 32'd0;
               step_idx_next = step_idx_reg + STEP_W'(1);
               end_next      = step_last;
            end else begin
               dly_cnt_next = dly_cnt_reg - 32'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // bus outputs decode straight from state so reset clears them asynchronously
   assign in_write       = (state_reg == WRITE);
   assign csr_sum        = CSR_BASE + {24'd0, step.offset};
   assign unused_adr_lsb = ^csr_sum[1:0];

   assign wb_adr   = in_write ? csr_sum[31:2] : 30'd0;
   assign wb_dat_w = in_write ? step.data : 32'd0;
   assign wb_sel   = in_write ? 4'hF : 4'h0;
   assign wb_we    = in_write;
   assign wb_cyc   = in_write;
   assign wb_stb   = in_write;

   assign busy  = (state_reg == FETCH) || (state_reg == WRITE) || (state_reg == DELAY);
   assign done  = (state_reg == DONE);
   assign error = (state_reg == ERROR);

endmodule
